// File: rtl/waveform_player_if.sv
// Handshake and table bus between the waveform converter/controller and waveform_player.
interface waveform_player_if #(
    parameter int DW      = 8,
    parameter int PHASE_W = 16
);
    logic                   src_rdy_flg;
    logic [0:255][DW-1:0]   wave_buf_in;
    logic                   load_req;
    logic                   play_en;
    logic [PHASE_W-1:0]     tuning_word;
    logic [DW-1:0]          sample_out;
    logic                   sample_vld;
    logic                   sample_rdy;
    logic                   loaded;
    logic                   busy;
    logic                   wrap_pulse;

    modport master (
        output src_rdy_flg, wave_buf_in, load_req, play_en, tuning_word, sample_rdy,
        input  sample_out, sample_vld, loaded, busy, wrap_pulse
    );

    modport slave (
        input  src_rdy_flg, wave_buf_in, load_req, play_en, tuning_word, sample_rdy,
        output sample_out, sample_vld, loaded, busy, wrap_pulse
    );
endinterface

// File: rtl/waveform_player.sv
// Phase-accumulator playback of a captured 256-entry waveform table with valid/ready output.
// Define WAVE_PLAYER_INTERP_EN to linearly interpolate between adjacent entries using the phase fraction.
module waveform_player #(
    parameter int DW      = 8,
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    waveform_player_if.slave   bus
);
    typedef enum logic [1:0] {EMPTY, LOADED, PLAY} state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        buf_q [256];
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [DW-1:0]        sample_q, sample_d;
    logic                 vld_q, vld_d;
    logic                 wrap_q, wrap_d;
    logic                 carry;
    logic                 capture, issue;
    logic [7:0]           idx;
    logic [DW-1:0]        samp_val;

    assign capture = bus.load_req && bus.src_rdy_flg;
    assign issue   = (state_q == PLAY) && bus.play_en && (!vld_q || bus.sample_rdy);
    assign idx     = phase_q[PHASE_W-1 -: 8];

`ifdef WAVE_PLAYER_INTERP_EN
    logic [7:0]            frac;
    logic [DW-1:0]         a_s, b_s;
    logic signed [DW:0]    diff;
    logic signed [DW+9:0]  prod;

    assign frac     = phase_q[PHASE_W-9 -: 8];
    assign a_s      = buf_q[idx];
    assign b_s      = buf_q[idx + 8'd1];
    assign diff     = $signed({1'b0, b_s}) - $signed({1'b0, a_s});
    assign prod     = diff * $signed({1'b0, frac});
    // The interpolated value always lies between a and b, so the low DW bits are exact.
    assign samp_val = DW'($signed({10'd0, a_s}) + (prod >>> 8));
`else
    assign samp_val = buf_q[idx];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EMPTY;
            phase_q  <= '0;
            sample_q <= '0;
            vld_q    <= 1'b0;
            wrap_q   <= 1'b0;
            for (int i = 0; i < 256; i++) buf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
            vld_q    <= vld_d;
            wrap_q   <= wrap_d;
            if (capture)
                for (int i = 0; i < 256; i++) buf_q[i] <= bus.wave_buf_in[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (capture)      state_d = LOADED;
            LOADED:  if (bus.play_en)  state_d = PLAY;
            PLAY:    if (!bus.play_en) state_d = LOADED;
            default:                   state_d = EMPTY;
        endcase
    end

    // An issue on the capture edge reads the old table/phase; capture then restarts phase at 0.
    always_comb begin
        sample_d = sample_q;
        vld_d    = vld_q;
        wrap_d   = 1'b0;
        phase_d  = phase_q;
        carry    = 1'b0;
        if (issue) begin
            sample_d         = samp_val;
            vld_d            = 1'b1;
            {carry, phase_d} = {1'b0, phase_q} + {1'b0, bus.tuning_word};
            wrap_d           = carry;
        end else if (vld_q && bus.sample_rdy) begin
            vld_d = 1'b0;
        end
        if (capture) phase_d = '0;
    end

    always_comb begin
        bus.busy       = (state_q == PLAY);
        bus.loaded     = (state_q != EMPTY);
        bus.sample_out = sample_q;
        bus.sample_vld = vld_q;
        bus.wrap_pulse = wrap_q;
    end
endmodule
